rx_buffer: RTL and testbench



---
 rtl/rx_buffer_pkg.sv | 10 +
 rtl/rx_buffer_mem.sv | 50 +++++
 rtl/rx_buffer.sv | 117 +++++++++++
 tb/tb_rx_buffer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/rx_buffer_pkg.sv
// Shared constants for the receive buffer: terminator characters and default geometry.
package rx_buffer_pkg;

    localparam int unsigned RX_DEPTH_DEFAULT = 32;
    localparam int unsigned RX_WIDTH_DEFAULT = 8;

    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_CR = 8'h0D;

endpackage : rx_buffer_pkg

// File: rtl/rx_buffer_mem.sv
// DEPTH x WIDTH storage with one synchronous write port and one registered read port.
// The read register clears on reset and holds its value when no read is requested.
module rx_buffer_mem
    import rx_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = RX_DEPTH_DEFAULT,
    parameter int unsigned WIDTH = RX_WIDTH_DEFAULT,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_d;
    logic [WIDTH-1:0] rd_data_q;

    // Array write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Next read data: load the addressed entry on a read, otherwise hold.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    // Read data register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule : rx_buffer_mem

// File: rtl/rx_buffer.sv
// Receive FIFO with end-of-string detection.
// Optional macro RX_BUFFER_CR_EOS_EN: when defined, CR (8'h0D) counts as a
// terminator in addition to LF (8'h0A); otherwise CR is ordinary data.
module rx_buffer
    import rx_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = RX_DEPTH_DEFAULT,
    parameter int unsigned WIDTH = RX_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic             end_of_str
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] term_cnt_q, term_cnt_d;
    // One tag bit per entry marks stored terminators, so a read can
    // decrement the terminator counter on the same edge it pops the entry.
    logic [DEPTH-1:0] term_tag_q, term_tag_d;

    logic wr_accept;
    logic rd_accept;
    logic wr_is_term;
    logic rd_is_term;

    // Flags decode straight from the registered occupancy.
    assign full       = (count_q == CNT_W'(DEPTH));
    assign empty      = (count_q == '0);
    assign end_of_str = (term_cnt_q != '0);

    // Handshake: a read needs data; a write needs room, or a read freeing a slot.
    always_comb begin
        rd_accept = rd_en && !empty;
        wr_accept = wr_en && (!full || rd_accept);
    end

    // Terminator classification of the incoming and outgoing entries.
    always_comb begin
        wr_is_term = (wr_data == WIDTH'(ASCII_LF));
`ifdef RX_BUFFER_CR_EOS_EN
        wr_is_term = wr_is_term || (wr_data == WIDTH'(ASCII_CR));
`endif
        rd_is_term = rd_accept && term_tag_q[rd_ptr_q];
    end

    // Next-state for pointers, occupancy, terminator tags and counter.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        term_cnt_d = term_cnt_q;
        term_tag_d = term_tag_q;

        if (wr_accept) begin
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
            term_tag_d[wr_ptr_q] = wr_is_term;
        end
        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        case ({wr_accept && wr_is_term, rd_is_term})
            2'b10:   term_cnt_d = term_cnt_q + CNT_W'(1);
            2'b01:   term_cnt_d = term_cnt_q - CNT_W'(1);
            default: term_cnt_d = term_cnt_q;
        endcase
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            term_cnt_q <= '0;
            term_tag_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            term_cnt_q <= term_cnt_d;
            term_tag_q <= term_tag_d;
        end
    end

    rx_buffer_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_accept),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_data),
        .rd_en   (rd_accept),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_data)
    );

endmodule : rx_buffer

// File: tb/tb_rx_buffer.sv
// Directed self-checking bench for rx_buffer at default geometry (32 x 8).
module tb_rx_buffer;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       full;
    logic       empty;
    logic       end_of_str;

    int n_checks;
    int n_errors;

`ifdef RX_BUFFER_CR_EOS_EN
    localparam logic CR_EOS_EXP = 1'b1;
`else
    localparam logic CR_EOS_EXP = 1'b0;
`endif

    rx_buffer dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .full       (full),
        .empty      (empty),
        .end_of_str (end_of_str)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare observed against expected and count the outcome.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    logic [7:0] hola [5];

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        wr_data  = '0;
        hola[0] = 8'h48; hola[1] = 8'h4F; hola[2] = 8'h4C; hola[3] = 8'h41; hola[4] = 8'h0A;

        // Reset then idle
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_eos", 32'(end_of_str), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'h0);

        // "HOLA\n" then five reads
        for (int i = 0; i < 4; i++) push(hola[i]);
        check("hola_eos_before_lf", 32'(end_of_str), 32'd0);
        push(hola[4]);
        check("hola_eos_after_lf", 32'(end_of_str), 32'd1);
        for (int i = 0; i < 5; i++) begin
            pop();
            check($sformatf("hola_rd%0d", i), 32'(rd_data), 32'(hola[i]));
            if (i == 3) check("hola_eos_lf_pending", 32'(end_of_str), 32'd1);
        end
        check("hola_eos_drained", 32'(end_of_str), 32'd0);
        check("hola_empty", 32'(empty), 32'd1);

        // Fill to full, drop an overflow write, drain in order
        for (int i = 0; i < 32; i++) begin
            push(8'(i));
            if (i == 30) check("fill_not_full_31", 32'(full), 32'd0);
        end
        check("fill_full", 32'(full), 32'd1);
        push(8'hFF);
        check("ovf_full", 32'(full), 32'd1);
        for (int i = 0; i < 32; i++) begin
            pop();
            check($sformatf("drain_rd%0d", i), 32'(rd_data), 32'(i));
        end
        check("drain_empty", 32'(empty), 32'd1);

        // Read while empty is ignored: rd_data holds
        pop();
        check("empty_rd_hold", 32'(rd_data), 32'd31);
        check("empty_rd_still_empty", 32'(empty), 32'd1);

        // Simultaneous read+write while full
        for (int i = 0; i < 32; i++) push(8'(i));
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        wr_data = 8'hAA;
        tick();
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        check("rw_full_full", 32'(full), 32'd1);
        check("rw_full_rd_data", 32'(rd_data), 32'h0);
        for (int i = 1; i < 33; i++) begin
            pop();
            check($sformatf("rw_drain_rd%0d", i), 32'(rd_data), (i == 32) ? 32'hAA : 32'(i));
        end
        check("rw_drain_empty", 32'(empty), 32'd1);

        // Simultaneous read+write while empty performs only the write
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        wr_data = 8'h55;
        tick();
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        check("rw_empty_not_empty", 32'(empty), 32'd0);
        check("rw_empty_rd_hold", 32'(rd_data), 32'hAA);
        pop();
        check("rw_empty_rd55", 32'(rd_data), 32'h55);

        // Two LFs, read one at a time
        push(8'h0A);
        push(8'h0A);
        check("lf2_eos", 32'(end_of_str), 32'd1);
        pop();
        check("lf2_eos_after_first", 32'(end_of_str), 32'd1);
        pop();
        check("lf2_eos_after_second", 32'(end_of_str), 32'd0);

        // CR terminator depends on build option
        push(8'h0D);
        check("cr_eos", 32'(end_of_str), 32'(CR_EOS_EXP));
        pop();
        check("cr_rd", 32'(rd_data), 32'h0D);
        check("cr_eos_drained", 32'(end_of_str), 32'd0);

        // Mid-fill reset wins over concurrent write/read
        push(8'h11);
        push(8'h0A);
        push(8'h22);
        check("mid_not_empty", 32'(empty), 32'd0);
        check("mid_eos", 32'(end_of_str), 32'd1);
        rst     = 1'b1;
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        wr_data = 8'h33;
        tick();
        rst     = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        check("mid_rst_empty", 32'(empty), 32'd1);
        check("mid_rst_full", 32'(full), 32'd0);
        check("mid_rst_eos", 32'(end_of_str), 32'd0);
        check("mid_rst_rd_data", 32'(rd_data), 32'h0);
        pop();
        check("post_rst_rd_ignored", 32'(rd_data), 32'h0);
        push(8'h77);
        pop();
        check("post_rst_rd77", 32'(rd_data), 32'h77);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_rx_buffer
